// File: rtl/rx_accp_fifo_pkg.sv
// Shared CAN receive definitions: field widths, frame entry record and
// the FIFO operation encoding used by the receive acceptance FIFO.
package rx_accp_fifo_pkg;

    localparam int unsigned ID_W      = 11;
    localparam int unsigned DLC_W     = 4;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned ENTRY_W   = ID_W + DLC_W + DATA_W;
    localparam int unsigned OVR_CNT_W = 8;

    // One stored frame; data byte 0 sits in data[63:56].
    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [DLC_W-1:0]  dlc;
        logic [DATA_W-1:0] data;
    } rx_entry_t;

    // Per-cycle FIFO operation, encoded as {push, pop}.
    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/rx_accp_fifo_if.sv
// Receive FIFO bus: acceptance-checker write side plus host read side.
// master = checker/host driving the FIFO, slave = the FIFO itself.
interface rx_accp_fifo_if import rx_accp_fifo_pkg::*; #(
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              acpt_sts;
    logic [ID_W-1:0]   rcvd_prio_id;
    logic [DLC_W-1:0]  rcvd_dlc;
    logic [DATA_W-1:0] rcvd_data;
    logic              rd_ack;
    logic              clr_ovr;
    logic              rd_valid;
    logic [ID_W-1:0]   rd_id;
    logic [DLC_W-1:0]  rd_dlc;
    logic [DATA_W-1:0] rd_data;
    logic [CNT_W-1:0]  fifo_cnt;
    logic              ovr_flg;

    modport master (
        output acpt_sts, rcvd_prio_id, rcvd_dlc, rcvd_data, rd_ack, clr_ovr,
        input  rd_valid, rd_id, rd_dlc, rd_data, fifo_cnt, ovr_flg
    );

    modport slave (
        input  acpt_sts, rcvd_prio_id, rcvd_dlc, rcvd_data, rd_ack, clr_ovr,
        output rd_valid, rd_id, rd_dlc, rd_data, fifo_cnt, ovr_flg
    );

endinterface

// File: rtl/rx_fifo_mem.sv
// DEPTH x 79-bit frame storage: one synchronous write port, one
// asynchronous read port. Contents are intentionally not reset.
module rx_fifo_mem import rx_accp_fifo_pkg::*; #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  rx_entry_t        i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output rx_entry_t        o_rd_data
);

    rx_entry_t r_mem [DEPTH];

    // Store the incoming frame at the write address.
    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/rx_accp_fifo.sv
// Show-ahead receive FIFO for accepted CAN frames.
// Optional feature: define RX_FIFO_OVR_CNT_EN to add the 8-bit saturating
// dropped-frame counter output ovr_cnt.
module rx_accp_fifo import rx_accp_fifo_pkg::*; #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 g_rst,
    rx_accp_fifo_if.slave        bus
`ifdef RX_FIFO_OVR_CNT_EN
    ,
    output logic [OVR_CNT_W-1:0] ovr_cnt
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovr_flg;

    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_ovr;
    fifo_op_e         w_op;
    rx_entry_t        w_wr_entry;
    rx_entry_t        w_head;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_empty = (r_cnt == '0);

    // Decode this cycle's push/pop/overrun. A pop frees the head slot in the
    // same edge, so a write into a full FIFO alongside a pop is legal.
    always_comb begin
        w_pop  = 1'b0;
        w_push = 1'b0;
        w_ovr  = 1'b0;
        w_pop  = bus.rd_ack & ~w_empty;
        w_push = bus.acpt_sts & (~w_full | w_pop);
        w_ovr  = bus.acpt_sts & w_full & ~w_pop;
        w_op   = fifo_op_e'({w_push, w_pop});
    end

    assign w_wr_entry.id   = bus.rcvd_prio_id;
    assign w_wr_entry.dlc  = bus.rcvd_dlc;
    assign w_wr_entry.data = bus.rcvd_data;

    rx_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_mem (
        .clk       (clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

    // Advance pointers and occupancy according to the decoded operation.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (w_op)
                OP_PUSH: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_cnt    <= r_cnt + CNT_W'(1);
                end
                OP_POP: begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                    r_cnt    <= r_cnt - CNT_W'(1);
                end
                OP_BOTH: begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                default: ;
            endcase
        end
    end

    // Sticky overrun flag; a new overrun beats a same-cycle clear.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            r_ovr_flg <= 1'b0;
        end else if (w_ovr) begin
            r_ovr_flg <= 1'b1;
        end else if (bus.clr_ovr) begin
            r_ovr_flg <= 1'b0;
        end
    end

`ifdef RX_FIFO_OVR_CNT_EN
    logic [OVR_CNT_W-1:0] r_ovr_cnt;

    // Saturating dropped-frame counter; increment beats a same-cycle clear.
    always_ff @(posedge clk or posedge g_rst) begin
        if (g_rst) begin
            r_ovr_cnt <= '0;
        end else if (w_ovr) begin
            if (r_ovr_cnt != '1) begin
                r_ovr_cnt <= r_ovr_cnt + OVR_CNT_W'(1);
            end
        end else if (bus.clr_ovr) begin
            r_ovr_cnt <= '0;
        end
    end

    assign ovr_cnt = r_ovr_cnt;
`endif

    assign bus.rd_valid = ~w_empty;
    assign bus.rd_id    = w_head.id;
    assign bus.rd_dlc   = w_head.dlc;
    assign bus.rd_data  = w_head.data;
    assign bus.fifo_cnt = r_cnt;
    assign bus.ovr_flg  = r_ovr_flg;

endmodule

// File: tb/tb_rx_accp_fifo.sv
// Directed self-checking bench for rx_accp_fifo (DEPTH = 4).
// Checks of ovr_cnt are compiled only when RX_FIFO_OVR_CNT_EN is defined.
module tb_rx_accp_fifo;

    localparam int unsigned DEPTH = 4;

    logic clk;
    logic g_rst;
    int   n_tests;
    int   n_fail;

`ifdef RX_FIFO_OVR_CNT_EN
    logic [7:0] ovr_cnt;
`endif

    rx_accp_fifo_if #(.DEPTH(DEPTH)) bus ();

    rx_accp_fifo #(.DEPTH(DEPTH)) dut (
        .clk     (clk),
        .g_rst   (g_rst),
        .bus     (bus)
`ifdef RX_FIFO_OVR_CNT_EN
        ,
        .ovr_cnt (ovr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_frame(input logic [10:0] id, input logic [3:0] dlc, input logic [63:0] data);
        bus.rcvd_prio_id = id;
        bus.rcvd_dlc     = dlc;
        bus.rcvd_data    = data;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        g_rst   = 1'b1;
        bus.acpt_sts = 1'b0;
        bus.rd_ack   = 1'b0;
        bus.clr_ovr  = 1'b0;
        set_frame(11'h0, 4'h0, 64'h0);

        // Reset state
        tick();
        tick();
        check("rst_valid", 64'(bus.rd_valid), 64'd0);
        check("rst_cnt",   64'(bus.fifo_cnt), 64'd0);
        check("rst_ovr",   64'(bus.ovr_flg),  64'd0);
`ifdef RX_FIFO_OVR_CNT_EN
        check("rst_ovr_cnt", 64'(ovr_cnt), 64'd0);
`endif
        g_rst = 1'b0;
        tick();

        // Single frame, one-cycle visibility, then pop
        set_frame(11'h123, 4'd8, 64'h0011223344556677);
        bus.acpt_sts = 1'b1;
        tick();
        bus.acpt_sts = 1'b0;
        check("single_valid", 64'(bus.rd_valid), 64'd1);
        check("single_id",    64'(bus.rd_id),    64'h123);
        check("single_dlc",   64'(bus.rd_dlc),   64'd8);
        check("single_data",  bus.rd_data,       64'h0011223344556677);
        check("single_cnt",   64'(bus.fifo_cnt), 64'd1);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check("single_pop_valid", 64'(bus.rd_valid), 64'd0);
        check("single_pop_cnt",   64'(bus.fifo_cnt), 64'd0);

        // Pop on empty ignored, write on empty with rd_ack performed
        set_frame(11'h0AA, 4'd3, 64'hCAFE);
        bus.acpt_sts = 1'b1;
        bus.rd_ack   = 1'b1;
        tick();
        bus.acpt_sts = 1'b0;
        bus.rd_ack   = 1'b0;
        check("wr_empty_ack_cnt", 64'(bus.fifo_cnt), 64'd1);
        check("wr_empty_ack_id",  64'(bus.rd_id),    64'h0AA);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check("wr_empty_ack_pop", 64'(bus.fifo_cnt), 64'd0);

        // Fill with ids 1..4, dlc 9..12 (stored verbatim)
        for (int i = 1; i <= 4; i++) begin
            set_frame(11'(i), 4'(8 + i), 64'(i) * 64'h0101010101010101);
            bus.acpt_sts = 1'b1;
            tick();
        end
        bus.acpt_sts = 1'b0;
        check("fill_cnt",  64'(bus.fifo_cnt), 64'd4);
        check("fill_head", 64'(bus.rd_id),    64'h001);

        // Overrun: dropped, contents unchanged
        set_frame(11'h7FF, 4'd15, 64'hFFFF_FFFF_FFFF_FFFF);
        bus.acpt_sts = 1'b1;
        tick();
        bus.acpt_sts = 1'b0;
        check("ovr_flg",  64'(bus.ovr_flg),  64'd1);
        check("ovr_cnt4", 64'(bus.fifo_cnt), 64'd4);
        check("ovr_head", 64'(bus.rd_id),    64'h001);
`ifdef RX_FIFO_OVR_CNT_EN
        check("ovr_cnt_1", 64'(ovr_cnt), 64'd1);
`endif
        // Overrun and clear together: set/increment wins
        bus.acpt_sts = 1'b1;
        bus.clr_ovr  = 1'b1;
        tick();
        bus.acpt_sts = 1'b0;
        check("ovr_set_wins", 64'(bus.ovr_flg), 64'd1);
`ifdef RX_FIFO_OVR_CNT_EN
        check("ovr_cnt_inc_wins", 64'(ovr_cnt), 64'd2);
`endif
        tick();
        bus.clr_ovr = 1'b0;
        check("ovr_clr", 64'(bus.ovr_flg), 64'd0);
`ifdef RX_FIFO_OVR_CNT_EN
        check("ovr_cnt_clr", 64'(ovr_cnt), 64'd0);
`endif

        // Full with simultaneous write and pop
        set_frame(11'h055, 4'd5, 64'h5555);
        bus.acpt_sts = 1'b1;
        bus.rd_ack   = 1'b1;
        tick();
        bus.acpt_sts = 1'b0;
        bus.rd_ack   = 1'b0;
        check("full_wrpop_cnt", 64'(bus.fifo_cnt), 64'd4);
        check("full_wrpop_ovr", 64'(bus.ovr_flg),  64'd0);
        for (int i = 2; i <= 4; i++) begin
            check("order_id",  64'(bus.rd_id),  64'(i));
            check("order_dlc", 64'(bus.rd_dlc), 64'(8 + i));
            bus.rd_ack = 1'b1;
            tick();
            bus.rd_ack = 1'b0;
        end
        check("last_id",   64'(bus.rd_id),   64'h055);
        check("last_data", bus.rd_data,      64'h5555);
        bus.rd_ack = 1'b1;
        tick();
        bus.rd_ack = 1'b0;
        check("drain_valid", 64'(bus.rd_valid), 64'd0);
        check("drain_cnt",   64'(bus.fifo_cnt), 64'd0);

        // Wrap-around: 10 write/pop pairs
        for (int i = 0; i < 10; i++) begin
            set_frame(11'(12'h100 + i), 4'(i), 64'hA5A5_0000_0000_0000 + 64'(i));
            bus.acpt_sts = 1'b1;
            tick();
            bus.acpt_sts = 1'b0;
            check("wrap_id",   64'(bus.rd_id), 64'(12'h100 + i));
            check("wrap_data", bus.rd_data,    64'hA5A5_0000_0000_0000 + 64'(i));
            bus.rd_ack = 1'b1;
            tick();
            bus.rd_ack = 1'b0;
        end
        check("wrap_cnt", 64'(bus.fifo_cnt), 64'd0);

        // Reset mid-operation with 3 stored entries
        for (int i = 1; i <= 3; i++) begin
            set_frame(11'(12'h300 + i), 4'd2, 64'(i));
            bus.acpt_sts = 1'b1;
            tick();
        end
        bus.acpt_sts = 1'b0;
        check("pre_rst_cnt", 64'(bus.fifo_cnt), 64'd3);
        #2;
        g_rst = 1'b1;
        #1;
        check("mid_rst_valid", 64'(bus.rd_valid), 64'd0);
        check("mid_rst_cnt",   64'(bus.fifo_cnt), 64'd0);
        check("mid_rst_ovr",   64'(bus.ovr_flg),  64'd0);
        tick();
        g_rst = 1'b0;
        tick();
        set_frame(11'h3AA, 4'd7, 64'h0123_4567_89AB_CDEF);
        bus.acpt_sts = 1'b1;
        tick();
        bus.acpt_sts = 1'b0;
        check("post_rst_cnt",  64'(bus.fifo_cnt), 64'd1);
        check("post_rst_id",   64'(bus.rd_id),    64'h3AA);
        check("post_rst_data", bus.rd_data,       64'h0123_4567_89AB_CDEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
